// File: rtl/gb_defs.sv
// Shared definitions for the interrupt controller: source bit indices,
// register addresses, controller FSM encoding and the vector base.
package gb_defs;

   // Interrupt source bit positions (bit 0 = highest priority)
   localparam int INT_VBLANK = 0;
   localparam int INT_STAT   = 1;
   localparam int INT_TIMER  = 2;
   localparam int INT_SERIAL = 3;
   localparam int INT_JOYPAD = 4;

   localparam int NUM_INT_SRC = 5;

   // Memory-mapped register addresses
   localparam logic [15:0] IF_ADDR_DEFAULT = 16'hFF0F;
   localparam logic [15:0] IE_ADDR_DEFAULT = 16'hFFFF;

   // Vector for source k is INT_VEC_BASE + 8*k
   localparam logic [15:0] INT_VEC_BASE = 16'h0040;

   // Controller FSM states
   typedef enum logic [1:0] {
      INT_IDLE     = 2'd0,
      INT_REQ      = 2'd1,
      INT_DISPATCH = 2'd2
   } int_state_t;

   // Jump target for a given vector index
   function automatic logic [15:0] int_vector(input logic [2:0] idx);
      return INT_VEC_BASE + {10'd0, idx, 3'b000};
   endfunction

endpackage

// File: rtl/int_prio_enc.sv
// Lowest-set-bit priority encoder: bit 0 wins. Produces a valid flag and
// the 3-bit index of the winning request.
module int_prio_enc #(
   parameter int W = 5
) (
   input  logic [W-1:0] req,
   output logic         valid,
   output logic [2:0]   idx
);

   // Scan from the top down so the lowest set bit is the last assignment
   always_comb begin
      valid = |req;
      idx   = 3'd0;
      for (int i = W - 1; i >= 0; i--) begin
         if (req[i]) begin
            idx = 3'(i);
         end
      end
   end

endmodule

// File: rtl/int_ctrl_mod.sv
// Interrupt controller feeding the PC stage. Holds IF/IE/IME, raises a
// registered request to control, and on acknowledge latches the vector
// index of the highest-priority pending source (or flags a lost request).
// Optional feature macro: INT_CTRL_HALT_WAKE_EN adds a registered HALT
// wake-up output that ignores IME; without it halt_wake is tied low.
module int_ctrl_mod
   import gb_defs::*;
#(
   parameter int          NUM_INT = NUM_INT_SRC,
   parameter logic [15:0] IF_ADDR = IF_ADDR_DEFAULT,
   parameter logic [15:0] IE_ADDR = IE_ADDR_DEFAULT
) (
   input  logic               clock,
   input  logic               reset,
   input  logic [NUM_INT-1:0] int_req,
   input  logic [15:0]        mem_addr,
   input  logic [7:0]         mem_wr_data,
   input  logic               mem_wr,
   output logic [7:0]         mem_rd_data,
   input  logic               ime_set_dly,
   input  logic               ime_set_now,
   input  logic               ime_clr,
   input  logic               instr_boundary,
   input  logic               int_ack,
   output logic               int_pending,
   output logic [2:0]         int_pc_out,
   output logic               int_vec_zero,
   output logic               halt_wake
);

   logic [NUM_INT-1:0] if_reg, if_next;
   logic [7:0]         ie_reg, ie_next;
   logic               ime_reg, ime_next;
   logic               ime_dly_reg, ime_dly_next;
   logic               pend_reg, pend_next;
   logic [2:0]         pc_reg, pc_next;
   logic               vz_reg, vz_next;
   int_state_t         state_reg, state_next;

   logic [NUM_INT-1:0] masked;
   logic               cond;
   logic               enc_valid;
   logic [2:0]         enc_idx;
   logic               dispatch;
   logic               if_wr;
   logic               ie_wr;

   assign if_wr    = mem_wr && (mem_addr == IF_ADDR);
   assign ie_wr    = mem_wr && (mem_addr == IE_ADDR);
   assign masked   = ie_reg[NUM_INT-1:0] & if_reg;
   assign cond     = ime_reg && (|masked);
   // An ack is honoured in IDLE and REQ; a repeat strobe during DISPATCH is ignored
   assign dispatch = int_ack && (state_reg != INT_DISPATCH);

   int_prio_enc #(
      .W (NUM_INT)
   ) u_prio_enc (
      .req   (masked),
      .valid (enc_valid),
      .idx   (enc_idx)
   );

   // Per-bit IF update: CPU write or ack clear first, then hardware set on top
   genvar gi;
   generate
      for (gi = 0; gi < NUM_INT; gi++) begin : g_if_bit
         logic ack_clr;
         logic sw_val;
         assign ack_clr = dispatch && enc_valid && (enc_idx == 3'(gi));
         assign sw_val  = if_wr ? mem_wr_data[gi] : if_reg[gi];
         assign if_next[gi] = int_req[gi] | (sw_val & ~ack_clr);
      end
   endgenerate

   assign ie_next = ie_wr ? mem_wr_data : ie_reg;

   // IME control: later statements take priority (ack/DI > RETI > EI)
   always_comb begin
      ime_next     = ime_reg;
      ime_dly_next = ime_dly_reg;
      if (instr_boundary && ime_dly_reg) begin
         ime_next     = 1'b1;
         ime_dly_next = 1'b0;
      end
      if (ime_set_dly) begin
         ime_dly_next = 1'b1;
      end
      if (ime_set_now) begin
         ime_next = 1'b1;
      end
      if (ime_clr) begin
         ime_next     = 1'b0;
         ime_dly_next = 1'b0;
      end
      if (dispatch) begin
         ime_next     = 1'b0;
         ime_dly_next = 1'b0;
      end
   end

   // Next-state logic for the request/dispatch handshake
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         INT_IDLE: begin
            if (dispatch) begin
               state_next = INT_DISPATCH;
            end else if (pend_reg) begin
               state_next = INT_REQ;
            end
         end
         INT_REQ: begin
            if (dispatch) begin
               state_next = INT_DISPATCH;
            end else if (!cond) begin
               state_next = INT_IDLE;
            end
         end
         INT_DISPATCH: begin
            state_next = INT_IDLE;
         end
         default: begin
            state_next = INT_IDLE;
         end
      endcase
   end

   // Pending request is suppressed for the cycle spent in DISPATCH
   assign pend_next = cond && (state_next != INT_DISPATCH);

   // Latch the dispatched vector index, or flag a lost request
   always_comb begin
      pc_next = pc_reg;
      vz_next = vz_reg;
      if (dispatch) begin
         if (enc_valid) begin
            pc_next = enc_idx;
            vz_next = 1'b0;
         end else begin
            pc_next = 3'd0;
            vz_next = 1'b1;
         end
      end
   end

   // State registers
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         if_reg      <= '0;
         ie_reg      <= '0;
         ime_reg     <= 1'b0;
         ime_dly_reg <= 1'b0;
         pend_reg    <= 1'b0;
         pc_reg      <= 3'd0;
         vz_reg      <= 1'b0;
         state_reg   <= INT_IDLE;
      end else begin
         if_reg      <= if_next;
         ie_reg      <= ie_next;
         ime_reg     <= ime_next;
         ime_dly_reg <= ime_dly_next;
         pend_reg    <= pend_next;
         pc_reg      <= pc_next;
         vz_reg      <= vz_next;
         state_reg   <= state_next;
      end
   end

   // Register readback; unused upper IF bits read as 1
   always_comb begin
      mem_rd_data = 8'h00;
      if (mem_addr == IF_ADDR) begin
         mem_rd_data = {{(8 - NUM_INT){1'b1}}, if_reg};
      end else if (mem_addr == IE_ADDR) begin
         mem_rd_data = ie_reg;
      end
   end

   assign int_pending  = pend_reg;
   assign int_pc_out   = pc_reg;
   assign int_vec_zero = vz_reg;

`ifdef INT_CTRL_HALT_WAKE_EN
   logic halt_wake_reg;

   // HALT wake-up from any enabled flag, regardless of IME
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         halt_wake_reg <= 1'b0;
      end else begin
         halt_wake_reg <= |masked;
      end
   end

   assign halt_wake = halt_wake_reg;
`else
   assign halt_wake = 1'b0;
`endif

endmodule

// File: tb/tb_int_ctrl_mod.sv
// Directed testbench for int_ctrl_mod. Inputs are driven and outputs are
// sampled 1 time unit after each rising clock edge.
module tb_int_ctrl_mod;

   localparam logic [15:0] IF_A = 16'hFF0F;
   localparam logic [15:0] IE_A = 16'hFFFF;

   logic       clock = 1'b0;
   logic       reset;
   logic [4:0] int_req;
   logic [15:0] mem_addr;
   logic [7:0] mem_wr_data;
   logic       mem_wr;
   logic [7:0] mem_rd_data;
   logic       ime_set_dly;
   logic       ime_set_now;
   logic       ime_clr;
   logic       instr_boundary;
   logic       int_ack;
   logic       int_pending;
   logic [2:0] int_pc_out;
   logic       int_vec_zero;
   logic       halt_wake;

   int n_cmp  = 0;
   int n_fail = 0;
   logic [7:0] rd;

   int_ctrl_mod dut (
      .clock          (clock),
      .reset          (reset),
      .int_req        (int_req),
      .mem_addr       (mem_addr),
      .mem_wr_data    (mem_wr_data),
      .mem_wr         (mem_wr),
      .mem_rd_data    (mem_rd_data),
      .ime_set_dly    (ime_set_dly),
      .ime_set_now    (ime_set_now),
      .ime_clr        (ime_clr),
      .instr_boundary (instr_boundary),
      .int_ack        (int_ack),
      .int_pending    (int_pending),
      .int_pc_out     (int_pc_out),
      .int_vec_zero   (int_vec_zero),
      .halt_wake      (halt_wake)
   );

   always #5 clock = ~clock;

   // Advance one clock and drop all single-cycle strobes
   task automatic tick();
      @(posedge clock);
      #1;
      int_req        = 5'b0;
      mem_wr         = 1'b0;
      ime_set_dly    = 1'b0;
      ime_set_now    = 1'b0;
      ime_clr        = 1'b0;
      instr_boundary = 1'b0;
      int_ack        = 1'b0;
   endtask

   task automatic wr(input logic [15:0] a, input logic [7:0] d);
      mem_addr    = a;
      mem_wr_data = d;
      mem_wr      = 1'b1;
      tick();
   endtask

   task automatic rd_reg(input logic [15:0] a, output logic [7:0] d);
      mem_addr = a;
      #1;
      d = mem_rd_data;
   endtask

   task automatic test_reset();
      reset = 1'b0;
      repeat (2) tick();
      n_cmp++; if (int_pending !== 1'b0) begin n_fail++; $display("FAIL rst_pending: got %b want 0", int_pending); end
      n_cmp++; if (int_pc_out !== 3'd0) begin n_fail++; $display("FAIL rst_pc: got %0d want 0", int_pc_out); end
      n_cmp++; if (int_vec_zero !== 1'b0) begin n_fail++; $display("FAIL rst_vz: got %b want 0", int_vec_zero); end
      n_cmp++; if (halt_wake !== 1'b0) begin n_fail++; $display("FAIL rst_halt: got %b want 0", halt_wake); end
      reset = 1'b1;
      rd_reg(IF_A, rd);
      n_cmp++; if (rd !== 8'hE0) begin n_fail++; $display("FAIL rst_if: got %h want e0", rd); end
      rd_reg(IE_A, rd);
      n_cmp++; if (rd !== 8'h00) begin n_fail++; $display("FAIL rst_ie: got %h want 00", rd); end
      rd_reg(16'h1234, rd);
      n_cmp++; if (rd !== 8'h00) begin n_fail++; $display("FAIL rd_other: got %h want 00", rd); end
      // Reach REQ, then reset asynchronously
      wr(IE_A, 8'h1F);
      ime_set_now = 1'b1;
      int_req = 5'b00001;
      tick();
      tick();
      tick();
      n_cmp++; if (int_pending !== 1'b1) begin n_fail++; $display("FAIL req_pending: got %b want 1", int_pending); end
      reset = 1'b0;
      #1;
      n_cmp++; if (int_pending !== 1'b0) begin n_fail++; $display("FAIL midreq_pending: got %b want 0", int_pending); end
      rd_reg(IF_A, rd);
      n_cmp++; if (rd !== 8'hE0) begin n_fail++; $display("FAIL midreq_if: got %h want e0", rd); end
      rd_reg(IE_A, rd);
      n_cmp++; if (rd !== 8'h00) begin n_fail++; $display("FAIL midreq_ie: got %h want 00", rd); end
      tick();
      reset = 1'b1;
      tick();
      n_cmp++; if (int_pending !== 1'b0) begin n_fail++; $display("FAIL postrst_pending: got %b want 0", int_pending); end
      $display("test_reset done");
   endtask

   task automatic test_dispatch();
      wr(IE_A, 8'h1F);
      ime_set_now = 1'b1;
      int_req = 5'b00110;
      tick();
      tick();
      n_cmp++; if (int_pending !== 1'b1) begin n_fail++; $display("FAIL disp_pending: got %b want 1", int_pending); end
      tick();
      int_ack = 1'b1;
      tick();
      n_cmp++; if (int_pc_out !== 3'd1) begin n_fail++; $display("FAIL disp_pc: got %0d want 1", int_pc_out); end
      n_cmp++; if (int_vec_zero !== 1'b0) begin n_fail++; $display("FAIL disp_vz: got %b want 0", int_vec_zero); end
      n_cmp++; if (int_pending !== 1'b0) begin n_fail++; $display("FAIL disp_pend_low: got %b want 0", int_pending); end
      rd_reg(IF_A, rd);
      n_cmp++; if (rd !== 8'hE4) begin n_fail++; $display("FAIL disp_if: got %h want e4", rd); end
      tick();
      tick();
      n_cmp++; if (int_pending !== 1'b0) begin n_fail++; $display("FAIL disp_ime_clr: got %b want 0", int_pending); end
      wr(IF_A, 8'h00);
      $display("test_dispatch done");
   endtask

   task automatic test_ei_delay();
      ime_set_dly = 1'b1;
      int_req = 5'b01000;
      tick();
      n_cmp++; if (int_pending !== 1'b0) begin n_fail++; $display("FAIL ei_after_ei: got %b want 0", int_pending); end
      instr_boundary = 1'b1;
      tick();
      n_cmp++; if (int_pending !== 1'b0) begin n_fail++; $display("FAIL ei_at_bnd: got %b want 0", int_pending); end
      tick();
      n_cmp++; if (int_pending !== 1'b1) begin n_fail++; $display("FAIL ei_after_bnd: got %b want 1", int_pending); end
      int_ack = 1'b1;
      tick();
      n_cmp++; if (int_pc_out !== 3'd3) begin n_fail++; $display("FAIL ei_pc: got %0d want 3", int_pc_out); end
      tick();
      // EI followed by DI: IME must never come on
      int_req = 5'b01000;
      ime_set_dly = 1'b1;
      tick();
      ime_clr = 1'b1;
      tick();
      instr_boundary = 1'b1;
      tick();
      tick();
      n_cmp++; if (int_pending !== 1'b0) begin n_fail++; $display("FAIL ei_di_1: got %b want 0", int_pending); end
      tick();
      n_cmp++; if (int_pending !== 1'b0) begin n_fail++; $display("FAIL ei_di_2: got %b want 0", int_pending); end
      wr(IF_A, 8'h00);
      $display("test_ei_delay done");
   endtask

   task automatic test_if_set_wins();
      int_req = 5'b00100;
      tick();
      int_req = 5'b00100;
      wr(IF_A, 8'h00);
      rd_reg(IF_A, rd);
      n_cmp++; if (rd !== 8'hE4) begin n_fail++; $display("FAIL set_vs_wr: got %h want e4", rd); end
      // Ack clear of the same bit that hardware sets this cycle
      ime_set_now = 1'b1;
      tick();
      tick();
      int_ack = 1'b1;
      int_req = 5'b00100;
      tick();
      n_cmp++; if (int_pc_out !== 3'd2) begin n_fail++; $display("FAIL set_vs_ack_pc: got %0d want 2", int_pc_out); end
      rd_reg(IF_A, rd);
      n_cmp++; if (rd !== 8'hE4) begin n_fail++; $display("FAIL set_vs_ack_if: got %h want e4", rd); end
      tick();
      wr(IF_A, 8'h00);
      rd_reg(IF_A, rd);
      n_cmp++; if (rd !== 8'hE0) begin n_fail++; $display("FAIL if_clear: got %h want e0", rd); end
      $display("test_if_set_wins done");
   endtask

   task automatic test_lost_request();
      ime_set_now = 1'b1;
      int_req = 5'b00001;
      tick();
      tick();
      tick();
      wr(IF_A, 8'h00);
      int_ack = 1'b1;
      tick();
      n_cmp++; if (int_vec_zero !== 1'b1) begin n_fail++; $display("FAIL lost_vz: got %b want 1", int_vec_zero); end
      n_cmp++; if (int_pc_out !== 3'd0) begin n_fail++; $display("FAIL lost_pc: got %0d want 0", int_pc_out); end
      tick();
      n_cmp++; if (int_vec_zero !== 1'b1) begin n_fail++; $display("FAIL lost_vz_hold: got %b want 1", int_vec_zero); end
      // A real dispatch afterwards clears the flag
      ime_set_now = 1'b1;
      int_req = 5'b10000;
      tick();
      tick();
      int_ack = 1'b1;
      tick();
      n_cmp++; if (int_pc_out !== 3'd4) begin n_fail++; $display("FAIL joy_pc: got %0d want 4", int_pc_out); end
      n_cmp++; if (int_vec_zero !== 1'b0) begin n_fail++; $display("FAIL joy_vz: got %b want 0", int_vec_zero); end
      tick();
      $display("test_lost_request done");
   endtask

   task automatic test_halt_wake();
      logic exp_hw;
`ifdef INT_CTRL_HALT_WAKE_EN
      exp_hw = 1'b1;
`else
      exp_hw = 1'b0;
`endif
      wr(IE_A, 8'h10);
      rd_reg(IE_A, rd);
      n_cmp++; if (rd !== 8'h10) begin n_fail++; $display("FAIL ie_rd: got %h want 10", rd); end
      int_req = 5'b10000;
      tick();
      tick();
      n_cmp++; if (halt_wake !== exp_hw) begin n_fail++; $display("FAIL halt_wake: got %b want %b", halt_wake, exp_hw); end
      n_cmp++; if (int_pending !== 1'b0) begin n_fail++; $display("FAIL halt_pending: got %b want 0", int_pending); end
      $display("test_halt_wake done");
   endtask

   initial begin
      reset          = 1'b0;
      int_req        = 5'b0;
      mem_addr       = 16'h0000;
      mem_wr_data    = 8'h00;
      mem_wr         = 1'b0;
      ime_set_dly    = 1'b0;
      ime_set_now    = 1'b0;
      ime_clr        = 1'b0;
      instr_boundary = 1'b0;
      int_ack        = 1'b0;
      test_reset();
      test_dispatch();
      test_ei_delay();
      test_if_set_wins();
      test_lost_request();
      test_halt_wake();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
